alu_param: RTL

ALU_PARAM -- requirements
Module: alu_param

---
 rtl/alu_param.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_param.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative Booth multiply, serial shifts.
// Define ALU_PARAM_DIV_EN to build the non-restoring divider (opcode 3) and its CORR state.
module alu_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             error,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
                         OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ASR = 4'd10;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CORR, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       op_reg;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    amt;

  // Accumulator carries one guard bit so a most-negative multiplicand stays exact.
  logic [WIDTH:0]   mul_a, mul_sum, mul_a_next, m_ext;
  logic [WIDTH-1:0] mul_q, mul_q_next;
  logic             mul_qm1;

  logic [WIDTH-1:0] sh_reg, sh_next;
  logic             sh_c_next;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_n, res_z, res_c, res_v, res_e;
  logic             exec_last, commit;

`ifdef ALU_PARAM_DIV_EN
  logic [WIDTH+1:0] div_r, div_r_sh, div_r_new, rem_fix, b_ext;
  logic [WIDTH-1:0] div_q, div_q_new;
  logic             go_corr;

  always_comb begin
    b_ext     = {2'b00, b_reg};
    div_r_sh  = {div_r[WIDTH:0], div_q[WIDTH-1]};
    div_r_new = div_r[WIDTH+1] ? (div_r_sh + b_ext) : (div_r_sh - b_ext);
    div_q_new = {div_q[WIDTH-2:0], ~div_r_new[WIDTH+1]};
    rem_fix   = div_r[WIDTH+1] ? (div_r + b_ext) : div_r;
    go_corr   = (op_reg == OP_DIV) && (b_reg != '0);
  end
`endif

  assign amt = b_reg[SW-1:0];

  always_comb begin
    m_ext = {b_reg[WIDTH-1], b_reg};
    case ({mul_q[0], mul_qm1})
      2'b01:   mul_sum = mul_a + m_ext;
      2'b10:   mul_sum = mul_a - m_ext;
      default: mul_sum = mul_a;
    endcase
    mul_a_next = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
    mul_q_next = {mul_sum[0], mul_q[WIDTH-1:1]};
  end

  always_comb begin
    case (op_reg)
      OP_SHL: begin
        sh_next   = {sh_reg[WIDTH-2:0], 1'b0};
        sh_c_next = sh_reg[WIDTH-1];
      end
      OP_SHR: begin
        sh_next   = {1'b0, sh_reg[WIDTH-1:1]};
        sh_c_next = sh_reg[0];
      end
      default: begin
        sh_next   = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
        sh_c_next = sh_reg[0];
      end
    endcase
  end

  always_comb begin
    case (op_reg)
      OP_MUL:                 exec_last = (cnt == SW'(WIDTH - 1));
`ifdef ALU_PARAM_DIV_EN
      OP_DIV:                 exec_last = (b_reg == '0) || (cnt == SW'(WIDTH - 1));
`endif
      OP_SHL, OP_SHR, OP_ASR: exec_last = (amt == '0) || (cnt == amt - 1'b1);
      default:                exec_last = 1'b1;
    endcase
`ifdef ALU_PARAM_DIV_EN
    commit = ((state == EXEC) && exec_last && !go_corr) || (state == CORR);
`else
    commit = (state == EXEC) && exec_last;
`endif
  end

  // Final results are formed from the values the last iteration is about to produce.
  always_comb begin
    res_lo = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_e  = 1'b0;
    add_w  = {1'b0, a_reg} + {1'b0, b_reg};
    sub_w  = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);
    case (op_reg)
      OP_ADD: begin
        res_lo = add_w[WIDTH-1:0];
        res_c  = add_w[WIDTH];
        res_v  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo = sub_w[WIDTH-1:0];
        res_c  = sub_w[WIDTH];
        res_v  = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (sub_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_MUL: {res_hi, res_lo} = {mul_a_next[WIDTH-1:0], mul_q_next};
`ifdef ALU_PARAM_DIV_EN
      OP_DIV: begin
        if (b_reg == '0) begin
          res_lo = '1;
          res_hi = a_reg;
          res_e  = 1'b1;
        end else begin
          res_lo = div_q;
          res_hi = rem_fix[WIDTH-1:0];
        end
      end
`endif
      OP_AND: res_lo = a_reg & b_reg;
      OP_OR:  res_lo = a_reg | b_reg;
      OP_XOR: res_lo = a_reg ^ b_reg;
      OP_NOT: res_lo = ~a_reg;
      OP_SHL, OP_SHR, OP_ASR: begin
        if (amt == '0) begin
          res_lo = a_reg;
        end else begin
          res_lo = sh_next;
          res_c  = sh_c_next;
        end
      end
      default: res_e = 1'b1;
    endcase
    res_n = (op_reg == OP_MUL) ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
    res_z = (op_reg == OP_MUL) ? ({res_hi, res_lo} == '0) : (res_lo == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0; b_reg <= '0; op_reg <= '0; cnt <= '0;
      mul_a <= '0; mul_q <= '0; mul_qm1 <= 1'b0; sh_reg <= '0;
`ifdef ALU_PARAM_DIV_EN
      div_r <= '0; div_q <= '0;
`endif
      result_lo <= '0; result_hi <= '0;
      negative <= 1'b0; zero <= 1'b0; carry <= 1'b0; overflow <= 1'b0; error <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            op_reg <= s;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          cnt     <= '0;
          error   <= 1'b0;
          mul_a   <= '0;
          mul_q   <= a_reg;
          mul_qm1 <= 1'b0;
          sh_reg  <= a_reg;
`ifdef ALU_PARAM_DIV_EN
          div_r   <= '0;
          div_q   <= a_reg;
`endif
          state   <= EXEC;
        end
        EXEC: begin
          cnt     <= cnt + 1'b1;
          mul_a   <= mul_a_next;
          mul_q   <= mul_q_next;
          mul_qm1 <= mul_q[0];
          sh_reg  <= sh_next;
`ifdef ALU_PARAM_DIV_EN
          div_r   <= div_r_new;
          div_q   <= div_q_new;
          if (exec_last) begin
            if (go_corr) begin
              state <= CORR;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
`else
          if (exec_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
`endif
        end
`ifdef ALU_PARAM_DIV_EN
        CORR: begin
          state <= DONE;
          done  <= 1'b1;
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        result_lo <= res_lo;
        result_hi <= res_hi;
        negative  <= res_n;
        zero      <= res_z;
        carry     <= res_c;
        overflow  <= res_v;
        error     <= res_e;
      end
    end
  end
endmodule
